// File: rtl/axi_rd_arbiter_if.sv
// Bundle of requester-side and AXI read-master signals for axi_rd_arbiter.
// master = the arbiter's view; slave = requesters plus the downstream AXI slave.
interface axi_rd_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      s_arvalid_i;
  logic [NREQ*32-1:0]   s_araddr_i;
  logic [NREQ-1:0]      s_arready_o;
  logic [NREQ-1:0]      s_rvalid_o;
  logic [63:0]          s_rdata_o;
  logic                 s_rlast_o;
  logic [NREQ-1:0]      s_rready_i;
  logic [NREQ-1:0]      err_o;

  logic                 m_axi_arvalid;
  logic [31:0]          m_axi_araddr;
  logic [5:0]           m_axi_arid;
  logic                 m_axi_arready;
  logic [1:0]           m_axi_arburst;
  logic [2:0]           m_axi_arsize;
  logic [3:0]           m_axi_arlen;
  logic [1:0]           m_axi_arlock;
  logic [2:0]           m_axi_arprot;
  logic [3:0]           m_axi_arcache;
  logic [3:0]           m_axi_arqos;

  logic                 m_axi_rvalid;
  logic                 m_axi_rlast;
  logic [1:0]           m_axi_rresp;
  logic [63:0]          m_axi_rdata;
  logic [5:0]           m_axi_rid;
  logic                 m_axi_rready;

  // Debug view of the AR FSM state (0 = IDLE, 1 = ISSUE).
  logic [0:0]           ar_state;

  modport master (
    input  s_arvalid_i, s_araddr_i, s_rready_i,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rlast, m_axi_rresp, m_axi_rdata, m_axi_rid,
    output s_arready_o, s_rvalid_o, s_rdata_o, s_rlast_o, err_o,
    output m_axi_arvalid, m_axi_araddr, m_axi_arid,
    output m_axi_arburst, m_axi_arsize, m_axi_arlen, m_axi_arlock,
    output m_axi_arprot, m_axi_arcache, m_axi_arqos,
    output m_axi_rready, ar_state
  );

  modport slave (
    output s_arvalid_i, s_araddr_i, s_rready_i,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rlast, m_axi_rresp, m_axi_rdata, m_axi_rid,
    input  s_arready_o, s_rvalid_o, s_rdata_o, s_rlast_o, err_o,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arid,
    input  m_axi_arburst, m_axi_arsize, m_axi_arlen, m_axi_arlock,
    input  m_axi_arprot, m_axi_arcache, m_axi_arqos,
    input  m_axi_rready, ar_state
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// N-requester AXI read-address arbiter with per-requester outstanding-burst limits and R routing by ID.
// Define AXI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both 1.
// AR: m_axi_arvalid/araddr/arid are held stable from assertion until m_axi_arready;
// s_arready_o is a one-cycle accept pulse that does not wait for anything downstream.
// R: m_axi_rready and s_rvalid_o are combinational from the current beat's rid.
module axi_rd_arbiter #(
  parameter int NREQ    = 2,
  parameter int MAX_OUT = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  axi_rd_arbiter_if.master   bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  logic [0:0]      state;
  logic [1:0]      grant;
  logic [31:0]     araddr;
  logic [3:0]      out_cnt [NREQ];
  logic [NREQ-1:0] err;

  logic [NREQ-1:0] eligible;
  logic            win_vld;
  logic [1:0]      win;
  logic [31:0]     win_addr;
  logic            ar_hs;
  logic            rready;
  logic            r_hs;
  logic [NREQ-1:0] cnt_inc;
  logic [NREQ-1:0] cnt_dec;
  logic [NREQ-1:0] err_set;

`ifndef AXI_ARB_FIXED_PRIO_EN
  logic [1:0]      rr_ptr;
`endif

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      eligible[k] = bus.s_arvalid_i[k] && (out_cnt[k] < MAX_CNT);
    end
  end

`ifdef AXI_ARB_FIXED_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win     = 2'd0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (eligible[j]) begin
        win_vld = 1'b1;
        win     = 2'(j);
      end
    end
  end
`else
  // Scan starting at rr_ptr and wrapping; first eligible requester wins.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win     = 2'd0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!win_vld && (j == idx) && eligible[j]) begin
          win_vld = 1'b1;
          win     = 2'(j);
        end
      end
    end
  end
`endif

  always_comb begin
    win_addr = 32'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == 2'(k)) win_addr = bus.s_araddr_i[32*k +: 32];
    end
  end

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      bus.s_arready_o[k] = (state == IDLE) && win_vld && (win == 2'(k));
    end
  end

  assign ar_hs = (state == ISSUE) && bus.m_axi_arready;

  // IDs outside 0..NREQ-1 match no requester and are drained with rready=1.
  always_comb begin
    rready = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.m_axi_rid == 6'(k)) rready = bus.s_rready_i[k];
    end
  end

  assign r_hs = bus.m_axi_rvalid && rready;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      bus.s_rvalid_o[k] = bus.m_axi_rvalid && (bus.m_axi_rid == 6'(k));
      cnt_inc[k] = ar_hs && (grant == 2'(k));
      // A last beat arriving with no burst outstanding (e.g. after reset) is ignored.
      cnt_dec[k] = r_hs && bus.m_axi_rlast && (bus.m_axi_rid == 6'(k))
                   && (out_cnt[k] != 4'd0);
      err_set[k] = r_hs && (bus.m_axi_rresp != 2'b00) && (bus.m_axi_rid == 6'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      grant  <= 2'd0;
      araddr <= 32'd0;
      err    <= '0;
`ifndef AXI_ARB_FIXED_PRIO_EN
      rr_ptr <= 2'd0;
`endif
      for (int k = 0; k < NREQ; k++) out_cnt[k] <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state  <= ISSUE;
            grant  <= win;
            araddr <= win_addr;
          end
        end
        ISSUE: begin
          if (bus.m_axi_arready) begin
            state  <= IDLE;
`ifndef AXI_ARB_FIXED_PRIO_EN
            rr_ptr <= (grant == 2'(NREQ - 1)) ? 2'd0 : grant + 2'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      for (int k = 0; k < NREQ; k++) begin
        if (cnt_inc[k] && !cnt_dec[k] && (out_cnt[k] != MAX_CNT)) begin
          out_cnt[k] <= out_cnt[k] + 4'd1;
        end else if (cnt_dec[k] && !cnt_inc[k]) begin
          out_cnt[k] <= out_cnt[k] - 4'd1;
        end
        if (err_set[k]) err[k] <= 1'b1;
      end
    end
  end

  assign bus.m_axi_arvalid = (state == ISSUE);
  assign bus.m_axi_araddr  = araddr;
  assign bus.m_axi_arid    = {4'd0, grant};
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arsize  = 3'b011;
  assign bus.m_axi_arlen   = 4'd15;
  assign bus.m_axi_arlock  = 2'd0;
  assign bus.m_axi_arprot  = 3'd0;
  assign bus.m_axi_arcache = 4'd0;
  assign bus.m_axi_arqos   = 4'd0;

  assign bus.m_axi_rready  = rready;
  assign bus.s_rdata_o     = bus.m_axi_rdata;
  assign bus.s_rlast_o     = bus.m_axi_rlast;
  assign bus.err_o         = err;
  assign bus.ar_state      = state;
endmodule
